// File: rtl/isdu_ctrl.sv
// isdu_ctrl: LC-3 subset instruction sequencing and decode unit.
// Moore FSM walking each instruction through fetch, decode and execute,
// driving every load enable, bus gate, mux select and SRAM strobe.
module isdu_ctrl (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       Mem_OE,
  output logic       Mem_WE
);

  typedef enum logic [4:0] {
    Halted, S_18, S_33_1, S_33_2, S_35, S_32,
    S_01, S_05, S_09, S_00, S_22, S_12, S_06, S_07,
    S_25_1, S_25_2, S_27, S_23, S_16_1, S_16_2,
    PauseIR1, PauseIR2
  } state_t;

  state_t state, next_state;

  // State register; reset takes priority over every transition.
  always_ff @(posedge Clk) begin
    if (Reset) state <= Halted;
    else       state <= next_state;
  end

  // Next-state selection and Moore output decode.
  always_comb begin
    next_state = state;
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    LD_IR      = 1'b0;
    LD_BEN     = 1'b0;
    LD_CC      = 1'b0;
    LD_REG     = 1'b0;
    LD_PC      = 1'b0;
    GatePC     = 1'b0;
    GateMDR    = 1'b0;
    GateALU    = 1'b0;
    GateMARMUX = 1'b0;
    PCMUX      = 2'b00;
    DRMUX      = 1'b0;
    SR1MUX     = 1'b0;
    SR2MUX     = 1'b0;
    ADDR1MUX   = 1'b0;
    ADDR2MUX   = 2'b00;
    ALUK       = 2'b00;
    Mem_OE     = 1'b1;
    Mem_WE     = 1'b1;

    unique case (state)
      Halted: if (Run) next_state = S_18;
      S_18: begin
        GatePC = 1'b1; LD_MAR = 1'b1; PCMUX = 2'b00; LD_PC = 1'b1;
        next_state = S_33_1;
      end
      S_33_1: begin
        Mem_OE = 1'b0;
        next_state = S_33_2;
      end
      S_33_2: begin
        Mem_OE = 1'b0; LD_MDR = 1'b1;
        next_state = S_35;
      end
      S_35: begin
        GateMDR = 1'b1; LD_IR = 1'b1;
        next_state = S_32;
      end
      S_32: begin
        LD_BEN = 1'b1;
        case (Opcode)
          4'b0001: next_state = S_01;
          4'b0101: next_state = S_05;
          4'b1001: next_state = S_09;
          4'b0000: next_state = S_00;
          4'b1100: next_state = S_12;
          4'b0110: next_state = S_06;
          4'b0111: next_state = S_07;
          4'b1101: next_state = PauseIR1;
          default: next_state = S_18;
        endcase
      end
      S_01, S_05: begin
        SR1MUX = 1'b1; SR2MUX = IR_5;
        ALUK = (state == S_05) ? 2'b01 : 2'b00;
        GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
        next_state = S_18;
      end
      S_09: begin
        SR1MUX = 1'b1; ALUK = 2'b10;
        GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
        next_state = S_18;
      end
      S_00: next_state = BEN ? S_22 : S_18;
      S_22: begin
        ADDR1MUX = 1'b0; ADDR2MUX = 2'b10; PCMUX = 2'b10; LD_PC = 1'b1;
        next_state = S_18;
      end
      S_12: begin
        SR1MUX = 1'b1; ALUK = 2'b11; GateALU = 1'b1;
        PCMUX = 2'b01; LD_PC = 1'b1;
        next_state = S_18;
      end
      S_06, S_07: begin
        SR1MUX = 1'b1; ADDR1MUX = 1'b1; ADDR2MUX = 2'b01;
        GateMARMUX = 1'b1; LD_MAR = 1'b1;
        next_state = (state == S_06) ? S_25_1 : S_23;
      end
      S_25_1: begin
        Mem_OE = 1'b0;
        next_state = S_25_2;
      end
      S_25_2: begin
        Mem_OE = 1'b0; LD_MDR = 1'b1;
        next_state = S_27;
      end
      S_27: begin
        GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
        next_state = S_18;
      end
      // MDR loads from the bus here because Mem_OE stays high.
      S_23: begin
        SR1MUX = 1'b0; ALUK = 2'b11; GateALU = 1'b1; LD_MDR = 1'b1;
        next_state = S_16_1;
      end
      S_16_1: begin
        Mem_WE = 1'b0;
        next_state = S_16_2;
      end
      S_16_2: begin
        Mem_WE = 1'b0;
        next_state = S_18;
      end
      PauseIR1: if (Continue)  next_state = PauseIR2;
      PauseIR2: if (!Continue) next_state = S_18;
      default: next_state = Halted;
    endcase
  end

endmodule

// File: tb/tb_isdu_ctrl.sv
// Directed self-checking bench for isdu_ctrl: every cycle's full output
// word is compared against the expected per-state control word.
module tb_isdu_ctrl;

  logic       Clk = 1'b0;
  logic       Reset, Run, Continue, IR_5, BEN;
  logic [3:0] Opcode;
  logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC;
  logic       GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0] PCMUX, ADDR2MUX, ALUK;
  logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX, Mem_OE, Mem_WE;

  typedef struct packed {
    logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc;
    logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux;
    logic       drmux, sr1mux, sr2mux, addr1mux;
    logic [1:0] addr2mux, aluk;
    logic       mem_oe, mem_we;
  } outs_t;

  typedef enum {
    T_HALT, T_18, T_33_1, T_33_2, T_35, T_32, T_01, T_05, T_09, T_00,
    T_22, T_12, T_06, T_07, T_25_1, T_25_2, T_27, T_23, T_16_1, T_16_2,
    T_P1, T_P2
  } tstate_t;

  outs_t obs;
  int    errors = 0;
  int    checks = 0;

  isdu_ctrl dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
    .Opcode(Opcode), .IR_5(IR_5), .BEN(BEN),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
    .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU),
    .GateMARMUX(GateMARMUX), .PCMUX(PCMUX), .DRMUX(DRMUX),
    .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX),
    .ADDR2MUX(ADDR2MUX), .ALUK(ALUK), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
  );

  always #5 Clk = ~Clk;

  assign obs = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC,
                GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, DRMUX,
                SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK, Mem_OE, Mem_WE};

  // Expected control word for each state, written from the state table.
  function automatic outs_t exp_out(tstate_t s, logic ir5);
    outs_t o;
    o = '0;
    o.mem_oe = 1'b1;
    o.mem_we = 1'b1;
    case (s)
      T_18:   begin o.gate_pc = 1; o.ld_mar = 1; o.ld_pc = 1; end
      T_33_1: o.mem_oe = 0;
      T_33_2: begin o.mem_oe = 0; o.ld_mdr = 1; end
      T_35:   begin o.gate_mdr = 1; o.ld_ir = 1; end
      T_32:   o.ld_ben = 1;
      T_01:   begin o.sr1mux = 1; o.sr2mux = ir5; o.aluk = 2'b00;
                    o.gate_alu = 1; o.ld_reg = 1; o.ld_cc = 1; end
      T_05:   begin o.sr1mux = 1; o.sr2mux = ir5; o.aluk = 2'b01;
                    o.gate_alu = 1; o.ld_reg = 1; o.ld_cc = 1; end
      T_09:   begin o.sr1mux = 1; o.aluk = 2'b10;
                    o.gate_alu = 1; o.ld_reg = 1; o.ld_cc = 1; end
      T_22:   begin o.addr2mux = 2'b10; o.pcmux = 2'b10; o.ld_pc = 1; end
      T_12:   begin o.sr1mux = 1; o.aluk = 2'b11; o.gate_alu = 1;
                    o.pcmux = 2'b01; o.ld_pc = 1; end
      T_06, T_07: begin o.sr1mux = 1; o.addr1mux = 1; o.addr2mux = 2'b01;
                    o.gate_marmux = 1; o.ld_mar = 1; end
      T_25_1: o.mem_oe = 0;
      T_25_2: begin o.mem_oe = 0; o.ld_mdr = 1; end
      T_27:   begin o.gate_mdr = 1; o.ld_reg = 1; o.ld_cc = 1; end
      T_23:   begin o.aluk = 2'b11; o.gate_alu = 1; o.ld_mdr = 1; end
      T_16_1, T_16_2: o.mem_we = 0;
      default: ;
    endcase
    return o;
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input tstate_t s);
    outs_t e;
    e = exp_out(s, IR_5);
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, e);
    end
  endtask

  // Advance one cycle and check the state reached.
  task automatic nxt(input string tag, input tstate_t s);
    step();
    chk(tag, s);
  endtask

  // From S_18: the four remaining fetch/decode cycles.
  task automatic fetch(input string tag);
    nxt({tag, "_33_1"}, T_33_1);
    nxt({tag, "_33_2"}, T_33_2);
    nxt({tag, "_35"},   T_35);
    nxt({tag, "_32"},   T_32);
  endtask

  initial begin
    Reset = 1'b1; Run = 1'b0; Continue = 1'b0;
    Opcode = 4'b0001; IR_5 = 1'b1; BEN = 1'b0;
    step(); step();
    chk("reset_halt", T_HALT);
    Reset = 1'b0;
    for (int i = 0; i < 10; i++) nxt($sformatf("idle%0d", i), T_HALT);

    Run = 1'b1;
    nxt("run_s18", T_18);
    Run = 1'b0;

    // ADD immediate
    Opcode = 4'b0001; IR_5 = 1'b1;
    fetch("add"); nxt("add_s01", T_01); nxt("add_s18", T_18);
    // AND register
    Opcode = 4'b0101; IR_5 = 1'b0;
    fetch("and"); nxt("and_s05", T_05); nxt("and_s18", T_18);
    // NOT
    Opcode = 4'b1001;
    fetch("not"); nxt("not_s09", T_09); nxt("not_s18", T_18);
    // BR not taken
    Opcode = 4'b0000; BEN = 1'b0;
    fetch("brn"); nxt("brn_s00", T_00); nxt("brn_s18", T_18);
    // BR taken
    BEN = 1'b1;
    fetch("brt"); nxt("brt_s00", T_00); nxt("brt_s22", T_22);
    nxt("brt_s18", T_18);
    BEN = 1'b0;
    // JMP
    Opcode = 4'b1100;
    fetch("jmp"); nxt("jmp_s12", T_12); nxt("jmp_s18", T_18);
    // LDR
    Opcode = 4'b0110;
    fetch("ldr"); nxt("ldr_s06", T_06); nxt("ldr_s25_1", T_25_1);
    nxt("ldr_s25_2", T_25_2); nxt("ldr_s27", T_27); nxt("ldr_s18", T_18);
    // STR, with Run held high to show it is ignored outside Halted
    Opcode = 4'b0111; Run = 1'b1;
    fetch("str"); nxt("str_s07", T_07); nxt("str_s23", T_23);
    nxt("str_s16_1", T_16_1); nxt("str_s16_2", T_16_2); nxt("str_s18", T_18);
    Run = 1'b0;
    // Illegal opcode executes as NOP
    Opcode = 4'b1000;
    fetch("ill"); nxt("ill_s18", T_18);
    // PSE handshake; Continue high during fetch must be ignored
    Opcode = 4'b1101; Continue = 1'b1;
    nxt("pse_33_1", T_33_1); nxt("pse_33_2", T_33_2);
    Continue = 1'b0;
    nxt("pse_35", T_35); nxt("pse_32", T_32);
    for (int i = 0; i < 5; i++) nxt($sformatf("pse_p1_%0d", i), T_P1);
    Continue = 1'b1;
    for (int i = 0; i < 3; i++) nxt($sformatf("pse_p2_%0d", i), T_P2);
    Continue = 1'b0;
    nxt("pse_s18", T_18);
    Opcode = 4'b0111;
    nxt("pse_once", T_33_1);
    // STR cut short by reset in S_16_1
    nxt("rst_33_2", T_33_2); nxt("rst_35", T_35); nxt("rst_32", T_32);
    nxt("rst_s07", T_07); nxt("rst_s23", T_23); nxt("rst_s16_1", T_16_1);
    Reset = 1'b1;
    nxt("rst_halt", T_HALT);
    Reset = 1'b0;
    nxt("rst_stay", T_HALT);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
